// File: rtl/rshift_seq_16bit_pkg.sv
// -----------------------------------------------------------------------------
// rshift_seq_16bit_pkg
// Shared constants and types for the sequential 16-bit right shifter/rotator:
// operation mode encoding, FSM state encoding, stage count and the helper that
// maps a stage index to its shift amount.
// -----------------------------------------------------------------------------
package rshift_seq_16bit_pkg;

  localparam int DATA_W = 16;
  localparam int STAGES = 4;  // log2(DATA_W): one stage of 8/4/2/1 per cycle

  localparam logic MODE_ROR = 1'b0;  // rotate right
  localparam logic MODE_SRL = 1'b1;  // logical shift right, zero fill

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Stage 0 applies the largest step (8), stage 3 the smallest (1), so the
  // captured shift amount is consumed MSB first.
  function automatic logic [STAGES-1:0] stage_amount(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/rshift_seq_16bit_if.sv
// -----------------------------------------------------------------------------
// rshift_seq_16bit_if
// Request/result bundle of the sequential shifter.
//   start     : request, only honoured while busy=0
//   shift_in  : 16-bit operand
//   shift_val : shift/rotate amount 0..15
//   mode      : MODE_ROR / MODE_SRL
//   busy      : operation in flight
//   done      : one-cycle result-valid pulse
//   shift_out : result, held until the next done
// master = requester, slave = shifter.
// -----------------------------------------------------------------------------
interface rshift_seq_16bit_if;
  import rshift_seq_16bit_pkg::*;

  logic              start;
  logic [DATA_W-1:0] shift_in;
  logic [3:0]        shift_val;
  logic              mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] shift_out;

  modport master (
    output start, shift_in, shift_val, mode,
    input  busy, done, shift_out
  );

  modport slave (
    input  start, shift_in, shift_val, mode,
    output busy, done, shift_out
  );

endinterface

// File: rtl/rshift_stage.sv
// -----------------------------------------------------------------------------
// rshift_stage
// Combinational single-stage right shifter/rotator.
//   data    : operand
//   amount  : one-hot step size (8, 4, 2 or 1)
//   enable  : 0 passes data through unchanged
//   mode    : MODE_ROR wraps LSBs into the MSBs, MODE_SRL fills with zeros
//   result  : shifted/rotated data
// -----------------------------------------------------------------------------
module rshift_stage #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        amount,
  input  logic              enable,
  input  logic              mode,
  output logic [DATA_W-1:0] result
);
  import rshift_seq_16bit_pkg::*;

  logic [DATA_W-1:0] srl_val;
  logic [DATA_W-1:0] ror_val;

  assign srl_val = data >> amount;
  assign ror_val = srl_val | (data << (DATA_W - int'(amount)));

  always_comb begin
    // NOTE: assigning a default before any branch keeps always_comb from
    // inferring a latch when a path leaves the output untouched.
    result = data;
    if (enable) begin
      result = (mode == MODE_SRL) ? srl_val : ror_val;
    end
  end

endmodule

// File: rtl/rshift_seq_16bit.sv
// -----------------------------------------------------------------------------
// rshift_seq_16bit
// Sequential 16-bit right shifter/rotator. A request captured at edge E0 is
// processed over four cycles (stages 8, 4, 2, 1) through one shared
// rshift_stage; the result is registered and done pulses after E4, giving a
// fixed latency independent of the amount.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation without done
//   bus : rshift_seq_16bit_if.slave (start/operands in, busy/done/result out)
// -----------------------------------------------------------------------------
module rshift_seq_16bit #(
  parameter int DATA_W = 16,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rshift_seq_16bit_if.slave    bus
);
  import rshift_seq_16bit_pkg::*;

  localparam int CNT_W = $clog2(STAGES);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data_q;
  logic [STAGES-1:0]  amt_q;
  logic               mode_q;
  logic [DATA_W-1:0]  shift_out_q;
  logic               done_q;
  logic               busy;

  logic [STAGES-1:0]  stage_mask;
  logic               stage_en;
  logic [DATA_W-1:0]  stage_out;
  logic               accept;
  logic               last_stage;

  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign last_stage = (cnt_q == CNT_W'(STAGES - 1));

  // The stage counter selects which bit of the captured amount is consumed.
  assign stage_mask = stage_amount(cnt_q);
  assign stage_en   = |(amt_q & stage_mask);

  rshift_stage #(.DATA_W(DATA_W)) u_stage (
    .data   (data_q),
    .amount (stage_mask),
    .enable (stage_en),
    .mode   (mode_q),
    .result (stage_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_stage) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output logic: busy follows the state register only.
  always_comb begin
    busy = (state_q == ST_SHIFT);
  end

  // Datapath. Inputs are only looked at on the accept edge, so later changes
  // on the bus cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      data_q      <= '0;
      amt_q       <= '0;
      mode_q      <= MODE_ROR;
      shift_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        data_q <= bus.shift_in;
        amt_q  <= bus.shift_val;
        mode_q <= bus.mode;
        cnt_q  <= '0;
      end else if (state_q == ST_SHIFT) begin
        data_q <= stage_out;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (last_stage) begin
          shift_out_q <= stage_out;
          done_q      <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.shift_out = shift_out_q;

endmodule
